// File: rtl/key_filter_2.sv
// key_filter_2: two-channel push-button debouncer.
// Raw active-low key pins are synchronised and then filtered per channel.
// Each channel drives a clean active-low level plus one-cycle press and
// release pulses. Optional long-press detection is built when
// KEY_LONG_PRESS_EN is defined; otherwise key_long is tied low.

module key_filter_2_ch #(
  parameter logic [19:0] CNT_MAX  = 20'd1_000_000,
  parameter logic [25:0] LONG_MAX = 26'd50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_out,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  typedef enum logic [1:0] {IDLE, PRESS_FILT, DOWN, REL_FILT} state_t;

  logic [1:0]  sync_q, sync_d;
  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        out_q, out_d;
  logic        press_q, press_d;
  logic        rel_q, rel_d;
  logic        key_s;

  assign key_s = sync_q[1];

  // Two-flop synchroniser shift; idles high (released).
  always_comb sync_d = {sync_q[0], key_in};

  // Filter FSM: a level change is accepted only after CNT_MAX equal samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d = PRESS_FILT;
          cnt_d   = 20'd1;
        end else begin
          cnt_d   = 20'd0;
        end
      end
      PRESS_FILT: begin
        if (key_s) begin
          state_d = IDLE;
          cnt_d   = 20'd0;
        end else if (cnt_q == CNT_MAX - 20'd1) begin
          state_d = DOWN;
          out_d   = 1'b0;
          press_d = 1'b1;
          cnt_d   = 20'd0;
        end else begin
          cnt_d   = cnt_q + 20'd1;
        end
      end
      DOWN: begin
        if (key_s) begin
          state_d = REL_FILT;
          cnt_d   = 20'd1;
        end else begin
          cnt_d   = 20'd0;
        end
      end
      REL_FILT: begin
        if (!key_s) begin
          state_d = DOWN;
          cnt_d   = 20'd0;
        end else if (cnt_q == CNT_MAX - 20'd1) begin
          state_d = IDLE;
          out_d   = 1'b1;
          rel_d   = 1'b1;
          cnt_d   = 20'd0;
        end else begin
          cnt_d   = cnt_q + 20'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 20'd0;
        out_d   = 1'b1;
      end
    endcase
  end

  // Synchroniser, FSM and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= 20'd0;
      out_q   <= 1'b1;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign key_out     = out_q;
  assign key_press   = press_q;
  assign key_release = rel_q;

`ifdef KEY_LONG_PRESS_EN
  logic [25:0] long_q, long_d;
  logic        done_q, done_d;
  logic        lpul_q, lpul_d;

  // Long-press counter: runs while accepted-down (a release bounce does not
  // restart it), saturates at LONG_MAX-1 and fires once when seen there.
  always_comb begin
    long_d = long_q;
    done_d = done_q;
    lpul_d = 1'b0;
    if (state_d == IDLE) begin
      long_d = 26'd0;
      done_d = 1'b0;
    end else if (state_q == DOWN || state_q == REL_FILT) begin
      if (long_q != LONG_MAX - 26'd1) begin
        long_d = long_q + 26'd1;
      end else if (!done_q) begin
        lpul_d = 1'b1;
        done_d = 1'b1;
      end
    end
  end

  // Long-press state registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      long_q <= 26'd0;
      done_q <= 1'b0;
      lpul_q <= 1'b0;
    end else begin
      long_q <= long_d;
      done_q <= done_d;
      lpul_q <= lpul_d;
    end
  end

  assign key_long = lpul_q;
`else
  assign key_long = 1'b0;
`endif

endmodule

module key_filter_2 #(
  parameter logic [19:0] CNT_MAX  = 20'd1_000_000,
  parameter logic [25:0] LONG_MAX = 26'd50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [1:0] key_in,
  output logic [1:0] key_out,
  output logic [1:0] key_press,
  output logic [1:0] key_release,
  output logic [1:0] key_long
);

  localparam int NUM_KEYS = 2;

  // Independent per-key filter channels.
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_filter_2_ch #(
      .CNT_MAX  (CNT_MAX),
      .LONG_MAX (LONG_MAX)
    ) u_ch (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .key_in      (key_in[g]),
      .key_out     (key_out[g]),
      .key_press   (key_press[g]),
      .key_release (key_release[g]),
      .key_long    (key_long[g])
    );
  end

endmodule

// File: doc/key_filter_2.md
# key_filter_2

Two-channel push-button debouncer that sits directly upstream of the two-key LED controller. It takes the raw, asynchronous, active-low `key[1:0]` pins, synchronises and filters each channel independently, and drives a clean active-low level bus that the LED controller consumes unchanged. It also drives one-cycle press and release pulses for event-driven consumers.

## Interface
- `CNT_MAX`, default 20'd1_000_000: consecutive stable synchronised samples required to accept a level change (20 ms at 50 MHz); legal range 2..2^20-1.
- `LONG_MAX`, default 26'd50_000_000: cycles a key must be accepted-down before `key_long` fires (1 s at 50 MHz). Used only with `KEY_LONG_PRESS_EN`.
- `sys_clk`  in  1  system clock; the block's only clock.
- `sys_rst_n`  in  1  asynchronous active-low reset.
- `key_in`  in  2  raw button pins, active-low (1 = released), asynchronous to `sys_clk`.
- `key_out`  out  2  debounced level, active-low, registered; 2'b11 = none pressed.
- `key_press`  out  2  one-cycle high pulse per bit when that key is accepted pressed.
- `key_release`  out  2  one-cycle high pulse per bit when that key is accepted released.
- `key_long`  out  2  one-cycle high pulse per bit on long-press detection; constant 0 when the feature is compiled out.

## Operation
- Each bit passes through a 2-flop synchroniser. Both flops reset to 1.
- Each channel has its own 4-state FSM, a 20-bit filter counter `cnt`, and optionally a 26-bit long counter. The channels never interact.
- IDLE (`key_out`=1):
  - sync=0 -> PRESS_FILT with `cnt`=1.
  - Otherwise stay, with `cnt`=0.
- PRESS_FILT:
  - sync=1 -> IDLE with `cnt`=0 (bounce rejected, no pulse).
  - sync=0 and `cnt`==CNT_MAX-1 -> DOWN. Set `key_out`=0, pulse `key_press`, clear `cnt`.
  - Otherwise `cnt`++.
- DOWN (`key_out`=0):
  - sync=1 -> REL_FILT with `cnt`=1.
  - Otherwise stay, with `cnt`=0.
- REL_FILT:
  - sync=0 -> DOWN with `cnt`=0 (no pulse).
  - sync=1 and `cnt`==CNT_MAX-1 -> IDLE. Set `key_out`=1, pulse `key_release`, clear `cnt`.
  - Otherwise `cnt`++.
- A level change is therefore accepted after exactly CNT_MAX consecutive equal synchronised samples. Any opposite sample restarts the filter.
- `cnt` never exceeds CNT_MAX-1, so no wrap-around is possible.
- Both keys changing in the same cycle are handled independently. Their pulses can coincide.
- Reset asserted mid-filter or mid-press:
  - All FSMs return to IDLE; all counters clear.
  - `key_out`=2'b11, all pulses 0.
  - No release pulse is generated.

## Timing
- Reset values: `key_out`=2'b11, `key_press`=`key_release`=`key_long`=2'b00, synchronisers=1, all FSMs in IDLE.
- Let E be the first `sys_clk` edge sampling raw `key_in[i]` low, with the pin held low from then on.
  - The FSM first sees 0 at edge E+2.
  - `key_out[i]` falls on edge E+CNT_MAX+1.
  - `key_press[i]` is high for exactly the cycle following that edge.
- Release is symmetric: `key_out[i]` rises on edge E'+CNT_MAX+1, with `key_release[i]` high for one cycle.
- All outputs are registered. There are no combinational paths from `key_in`.

## Configuration
- Macro: `KEY_LONG_PRESS_EN`.
- Defined:
  - A per-channel long counter increments every cycle the FSM is in DOWN or REL_FILT, and clears on entering IDLE.
  - When it reaches LONG_MAX-1, `key_long[i]` pulses for one cycle and the counter saturates, giving one pulse per press.
  - A bounce that returns REL_FILT to DOWN does not restart the long counter.
- Undefined: the long counters are not built, and `key_long` is tied to 2'b00. The port list is unchanged.

## Test plan
Run the bench with CNT_MAX=20, LONG_MAX=100, and the macro defined unless stated otherwise.
- Reset, then raw `key_in`=2'b11 held -> `key_out`=2'b11 and all pulses 0 for 200 cycles.
- `key_in[0]` falls cleanly at edge E -> `key_out`=2'b10 on edge E+21, `key_press`=2'b01 for exactly one cycle; release likewise gives `key_out`=2'b11 and `key_release`=2'b01 once.
- `key_in[1]` toggles low 5 cycles, high 3 cycles, 4 times, then holds low -> no pulse during the bounces; `key_out[1]` falls 21 edges after the final falling edge; exactly one `key_press[1]`.
- Both keys fall on the same edge -> `key_out` goes 2'b11 -> 2'b00 in one step, `key_press`=2'b11 in one cycle.
- `key_in[0]` held low 200 cycles -> exactly one `key_long[0]` pulse, 100 cycles after `key_out[0]` falls; with the macro undefined, `key_long` stays 2'b00.
- `sys_rst_n` pulsed low while `key_out[0]`=0 and `key_in[1]` is mid-filter -> immediately `key_out`=2'b11 with no pulses; after reset release with keys held low, a fresh full filter runs before the press is accepted.
